// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: synchronises board switches, debounces SW8 and captures the switch bus on each debounced press.
module sw_input_conditioner #(
  parameter int n               = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [n-1:0]        sw_raw,
  input  logic                sw8_raw,
  output logic signed [n-1:0] sw_out,
  output logic                sw8_out,
  output logic                sw8_rise,
  output logic                sw8_fall
);
  localparam logic [1:0] STABLE_LO = 2'b00;
  localparam logic [1:0] WAIT_HI   = 2'b01;
  localparam logic [1:0] STABLE_HI = 2'b10;
  localparam logic [1:0] WAIT_LO   = 2'b11;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  logic [n:0]       s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [n-1:0]     sw_out_q, sw_out_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             hi_seen, lo_seen, pending, done;
  // state_q[1] is the debounced level; the counter is zero in both stable states,
  // so the current s2 cycle always counts as cnt_q+1 and a limit of 1 skips WAIT.
  always_comb begin
    hi_seen  = !state_q[1] && s2_q[n];
    lo_seen  = state_q[1] && !s2_q[n];
    pending  = hi_seen || lo_seen;
    cnt_inc  = cnt_q + CNT_W'(1);
    done     = pending && (cnt_inc == LIMIT);
    rise_d   = hi_seen && done;
    fall_d   = lo_seen && done;
    cnt_d    = (pending && !done) ? cnt_inc : '0;
    sw_out_d = rise_d ? s2_q[n-1:0] : sw_out_q;
    state_d  = rise_d ? STABLE_HI : fall_d ? STABLE_LO : hi_seen ? WAIT_HI :
               lo_seen ? WAIT_LO : state_q[1] ? STABLE_HI : STABLE_LO;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      sw_out_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= {sw8_raw, sw_raw};
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_out_q <= sw_out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end
  assign sw_out   = sw_out_q;
  assign sw8_out  = state_q[1];
  assign sw8_rise = rise_q;
  assign sw8_fall = fall_q;
endmodule
